// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register slave.
//   resp_t     : AXI response codes
//   wr_state_e : write-channel FSM states
//   rd_state_e : read-channel FSM states
//   merge()    : byte-lane merge of write data into an existing word
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_COMMIT,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

  // Replace the bytes of old selected by wstrb with the matching bytes of wdata.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
//   aclk, areset_n      : clock (rising edge), async active-low reset
//   AW*/W*/B*           : write address / data / response channels
//   AR*/R*              : read address / data channels
//   o_regs              : flattened register contents, reg k at [32k+31:32k]
//   o_wr_pulse          : one-cycle pulse for the register hit by a committed write
// One write and one read may be outstanding at a time; the two channels run
// independently. All outputs are registered, so no READY depends on a VALID.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] RST_VAL  = 32'h0
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic [ADDR_W-1:0]        AWADDR,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ADDR_W-1:0]        ARADDR,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [NUM_REGS*32-1:0]   o_regs,
  output logic [NUM_REGS-1:0]      o_wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Byte offset is ignored; any set bit above the register window is a miss.
  function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    dec_t              d;
    word  = addr >> 2;
    d.ok  = (word < ADDR_W'(NUM_REGS));
    d.idx = word[IDX_W-1:0];
    return d;
  endfunction

  logic [NUM_REGS-1:0][31:0] regs_q;
  logic [NUM_REGS-1:0]       pulse_q;

  // ---------------------------------------------------------------- write
  wr_state_e   wst_q;
  logic        awready_q, wready_q, bvalid_q;
  resp_t       bresp_q;
  dec_t        aw_dec_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_dec_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      pulse_q   <= '0;
      regs_q    <= {NUM_REGS{RST_VAL}};
    end else begin
      pulse_q <= '0;
      case (wst_q)
        W_IDLE: begin
          if (AWVALID && awready_q && WVALID && wready_q) begin
            aw_dec_q  <= decode(AWADDR);
            wdata_q   <= WDATA;
            wstrb_q   <= WSTRB;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wst_q     <= W_COMMIT;
          end else if (AWVALID && awready_q) begin
            aw_dec_q  <= decode(AWADDR);
            awready_q <= 1'b0;
            wst_q     <= W_HAVE_A;
          end else if (WVALID && wready_q) begin
            wdata_q  <= WDATA;
            wstrb_q  <= WSTRB;
            wready_q <= 1'b0;
            wst_q    <= W_HAVE_D;
          end
        end
        W_HAVE_A: begin
          if (WVALID && wready_q) begin
            wdata_q  <= WDATA;
            wstrb_q  <= WSTRB;
            wready_q <= 1'b0;
            wst_q    <= W_COMMIT;
          end
        end
        W_HAVE_D: begin
          if (AWVALID && awready_q) begin
            aw_dec_q  <= decode(AWADDR);
            awready_q <= 1'b0;
            wst_q     <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          // A miss still completes, just without touching any register.
          if (aw_dec_q.ok) begin
            regs_q[aw_dec_q.idx]  <= merge(regs_q[aw_dec_q.idx], wdata_q, wstrb_q);
            pulse_q[aw_dec_q.idx] <= 1'b1;
            bresp_q               <= RESP_OKAY;
          end else begin
            bresp_q <= RESP_SLVERR;
          end
          bvalid_q <= 1'b1;
          wst_q    <= W_RESP;
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wst_q     <= W_IDLE;
          end
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- read
  rd_state_e   rst_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  resp_t       rresp_q;
  dec_t        ar_dec;

  assign ar_dec = decode(ARADDR);

  // Sampling regs_q directly means a read captured on a commit edge
  // sees the pre-write contents.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rst_q)
        R_IDLE: begin
          if (ARVALID) begin
            rdata_q   <= ar_dec.ok ? regs_q[ar_dec.idx] : 32'h0;
            rresp_q   <= ar_dec.ok ? RESP_OKAY : RESP_SLVERR;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rst_q     <= R_RESP;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rst_q     <= R_IDLE;
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY    = awready_q;
  assign WREADY     = wready_q;
  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign ARREADY    = arready_q;
  assign RVALID     = rvalid_q;
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign o_regs     = regs_q;
  assign o_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
module tb_axi_lite_reg_slave;

  localparam int NR = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic [31:0]   AWADDR, WDATA, ARADDR, RDATA;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic [NR*32-1:0] o_regs;
  logic [NR-1:0] o_wr_pulse;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [NR];

  always #5 aclk = ~aclk;

  axi_lite_reg_slave #(.ADDR_W(32), .NUM_REGS(NR), .RST_VAL(32'h0)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .o_regs(o_regs), .o_wr_pulse(o_wr_pulse)
  );

  typedef struct {
    bit          wr;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          d1, d2, d3;  // wr: aw delay, w delay, bready delay; rd: ar delay, rready delay
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              int d1, int d2, int d3, logic [1:0] er, logic [31:0] ed);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.s = s; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.er = er; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm);
    logic [NR*32-1:0] f;
    for (int k = 0; k < NR; k++) f[32*k +: 32] = model[k];
    checks++;
    if (o_regs !== f) begin
      errors++;
      $display("FAIL %s regs: got %h expected %h", nm, o_regs, f);
    end
  endtask

  function automatic bit in_rng(logic [31:0] a);
    return (a >> 2) < 32'(NR);
  endfunction

  // Starts and ends half a tick after a rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int bd, output logic [1:0] resp);
    bit awdn = 0, wdn = 0, bdn = 0, bad = 0, aw_hs, w_hs, b_hs, ok;
    int cyc = 0, hs_cyc = -1, bv_cyc = -1, bvc = 0, pc = 0, idx;
    logic [NR-1:0] pv = '0;
    logic [31:0] m;
    resp = 2'bxx;
    while (!bdn && cyc < 200) begin
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = !awdn && cyc >= awd;
      WVALID  = !wdn && cyc >= wd;
      BREADY  = bvc >= bd;
      @(negedge aclk);
      if (o_wr_pulse != '0) begin pc++; pv |= o_wr_pulse; end
      if ((awdn && AWREADY) || (wdn && WREADY)) bad = 1;
      if (BVALID) begin
        if (bv_cyc < 0) begin bv_cyc = cyc; resp = BRESP; end
        else if (BRESP !== resp) bad = 1;
        bvc++;
      end
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
      @(posedge aclk); #1;
      if (aw_hs) awdn = 1;
      if (w_hs)  wdn = 1;
      if (b_hs)  bdn = 1;
      if ((aw_hs || w_hs) && awdn && wdn) hs_cyc = cyc;
      cyc++;
    end
    AWVALID = 0; WVALID = 0; BREADY = 0;
    ok  = in_rng(a);
    idx = int'(a[4:2]);
    if (ok) begin
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      model[idx] = (model[idx] & ~m) | (d & m);
    end
    chk("wr_done", 32'(bdn), 32'd1);
    chk("wr_latency", 32'(bv_cyc - hs_cyc), 32'd2);
    chk("bresp", 32'(resp), ok ? 32'(OKAY) : 32'(SLVERR));
    chk("wr_pulse_cycles", 32'(pc), ok ? 32'd1 : 32'd0);
    chk("wr_pulse_bit", 32'(pv), ok ? (32'd1 << idx) : 32'd0);
    chk("wr_hold", 32'(bad), 32'd0);
    @(negedge aclk);
    chk("wr_ready_back", 32'({AWREADY, WREADY}), 32'd3);
    chk_regs("wr");
    @(posedge aclk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input int ard, input int rd,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ardn = 0, rdn = 0, bad = 0, ar_hs, r_hs, ok;
    int cyc = 0, ar_cyc = -1, rv_cyc = -1, rvc = 0, idx;
    data = 'x; resp = 'x;
    while (!rdn && cyc < 200) begin
      ARADDR  = a;
      ARVALID = !ardn && cyc >= ard;
      RREADY  = rvc >= rd;
      @(negedge aclk);
      if (ardn && ARREADY) bad = 1;
      if (RVALID) begin
        if (rv_cyc < 0) begin rv_cyc = cyc; data = RDATA; resp = RRESP; end
        else if (RDATA !== data || RRESP !== resp) bad = 1;
        rvc++;
      end
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      @(posedge aclk); #1;
      if (ar_hs) begin ardn = 1; ar_cyc = cyc; end
      if (r_hs) rdn = 1;
      cyc++;
    end
    ARVALID = 0; RREADY = 0;
    ok  = in_rng(a);
    idx = int'(a[4:2]);
    chk("rd_done", 32'(rdn), 32'd1);
    chk("rd_latency", 32'(rv_cyc - ar_cyc), 32'd1);
    chk("rdata_model", data, ok ? model[idx] : 32'h0);
    chk("rresp_model", 32'(resp), ok ? 32'(OKAY) : 32'(SLVERR));
    chk("rd_hold", 32'(bad), 32'd0);
    @(negedge aclk);
    chk("rd_ready_back", 32'(ARREADY), 32'd1);
    @(posedge aclk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [1:0]  r;
    logic [31:0] rd, ra, rdat;

    areset_n = 0;
    AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0;
    for (int k = 0; k < NR; k++) model[k] = 32'h0;

    // reset state
    repeat (3) @(negedge aclk);
    chk("rst_readys", 32'({AWREADY, WREADY, ARREADY}), 32'd7);
    chk("rst_valids", 32'({BVALID, RVALID}), 32'd0);
    chk("rst_resps", 32'({BRESP, RRESP}), 32'd0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_pulse", 32'(o_wr_pulse), 32'd0);
    chk_regs("rst");
    #2 areset_n = 1;
    @(posedge aclk); #1;

    // directed vectors
    tbl.push_back(mk(1, 32'h04, 32'hA5A5_1234, 4'hF, 0, 0, 0, OKAY, 0));
    tbl.push_back(mk(0, 32'h04, 0, 0, 0, 0, 0, OKAY, 32'hA5A5_1234));
    tbl.push_back(mk(1, 32'h08, 32'h1111_1111, 4'hF, 1, 0, 0, OKAY, 0));
    tbl.push_back(mk(1, 32'h08, 32'hFFFF_BEEF, 4'h3, 3, 0, 0, OKAY, 0));
    tbl.push_back(mk(0, 32'h08, 0, 0, 0, 0, 0, OKAY, 32'h1111_BEEF));
    tbl.push_back(mk(1, 32'h00, 32'h0BAD_F00D, 4'hF, 0, 2, 5, OKAY, 0));
    tbl.push_back(mk(0, 32'h00, 0, 0, 1, 3, 0, OKAY, 32'h0BAD_F00D));
    tbl.push_back(mk(1, 32'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, SLVERR, 0));
    tbl.push_back(mk(0, 32'h1000_0000, 0, 0, 0, 0, 0, SLVERR, 32'h0));
    tbl.push_back(mk(1, 32'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, OKAY, 0));
    tbl.push_back(mk(0, 32'h0C, 0, 0, 0, 0, 0, OKAY, 32'h0));
    tbl.push_back(mk(1, 32'h1E, 32'h7777_0000, 4'hF, 0, 0, 1, OKAY, 0));
    tbl.push_back(mk(0, 32'h1D, 0, 0, 0, 0, 0, OKAY, 32'h7777_0000));
    tbl.push_back(mk(0, 32'h20, 0, 0, 0, 0, 0, SLVERR, 32'h0));
    tbl.push_back(mk(1, 32'h1C, 32'h00AA_0000, 4'h4, 2, 2, 0, OKAY, 0));
    tbl.push_back(mk(0, 32'h1C, 0, 0, 0, 1, 0, OKAY, 32'h77AA_0000));

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].d1, tbl[i].d2, tbl[i].d3, r);
        chk("tbl_bresp", 32'(r), 32'(tbl[i].er));
      end else begin
        do_read(tbl[i].a, tbl[i].d1, tbl[i].d2, rd, r);
        chk("tbl_rdata", rd, tbl[i].ed);
        chk("tbl_rresp", 32'(r), 32'(tbl[i].er));
      end
    end

    // read captured on the commit edge of a write to the same register
    do_write(32'h0C, 32'h1234_5678, 4'hF, 0, 0, 0, r);
    AWADDR = 32'h0C; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    @(negedge aclk);
    chk("coll_aw_w_ready", 32'({AWREADY, WREADY}), 32'd3);
    @(posedge aclk); #1;
    AWVALID = 0; WVALID = 0; ARADDR = 32'h0C; ARVALID = 1;
    @(negedge aclk);
    chk("coll_arready", 32'(ARREADY), 32'd1);
    @(posedge aclk); #1;
    ARVALID = 0;
    @(negedge aclk);
    chk("coll_rvalid_bvalid", 32'({RVALID, BVALID}), 32'd3);
    chk("coll_old_rdata", RDATA, 32'h1234_5678);
    chk("coll_new_reg", o_regs[3*32 +: 32], 32'hCAFE_F00D);
    RREADY = 1; BREADY = 1;
    @(posedge aclk); #1;
    RREADY = 0; BREADY = 0;
    model[3] = 32'hCAFE_F00D;
    do_read(32'h0C, 0, 0, rd, r);
    chk("coll_follow_rdata", rd, 32'hCAFE_F00D);

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      ra = 32'($urandom_range(0, 11)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(6, 31));
      if ($urandom_range(0, 1) == 1) begin
        rdat = $urandom;
        do_write(ra, rdat, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r);
      end else begin
        do_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd, r);
      end
    end

    // async reset while a write response is pending
    AWADDR = 32'h10; WDATA = 32'h5555_AAAA; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(posedge aclk); #1;
    AWVALID = 0; WVALID = 0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("pre_rst_bvalid", 32'(BVALID), 32'd1);
    chk("pre_rst_reg4", o_regs[4*32 +: 32], 32'h5555_AAAA);
    #2 areset_n = 0;
    #1;
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    chk("arst_bvalid", 32'(BVALID), 32'd0);
    chk("arst_readys", 32'({AWREADY, WREADY, ARREADY}), 32'd7);
    chk("arst_pulse", 32'(o_wr_pulse), 32'd0);
    chk_regs("arst");
    @(negedge aclk);
    #2 areset_n = 1;
    @(posedge aclk); #1;
    do_read(32'h10, 0, 0, rd, r);
    chk("post_rst_reg4", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
